// File: rtl/display_pkg.sv
// Shared types and constants for the display scan controller.
// Scan FSM states, segment/digit widths and the state-sequence helper.
package display_pkg;

  typedef enum logic [1:0] {
    ST_BLANK_T = 2'd0,
    ST_TENS    = 2'd1,
    ST_BLANK_O = 2'd2,
    ST_ONES    = 2'd3
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'b0;
  localparam int         DIGIT_W = 5;

  // Per-slot sequence: blank, tens, blank, ones, then back to blank of the next slot.
  function automatic state_t next_state(input state_t s);
    state_t n;
    n = ST_BLANK_T;
    case (s)
      ST_BLANK_T: n = ST_TENS;
      ST_TENS:    n = ST_BLANK_O;
      ST_BLANK_O: n = ST_ONES;
      ST_ONES:    n = ST_BLANK_T;
      default:    n = ST_BLANK_T;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Load port of the scan controller: one value set for all display slots.
// Handshake: a transfer happens on a rising clk edge where load_valid and load_ready are both high;
// the master holds load_data stable while load_valid is high and not yet accepted.
interface display_scan_ctrl_if #(
  parameter int N_DISP = 2
);
  import display_pkg::*;

  logic                        load_valid;
  logic [DIGIT_W*N_DISP-1:0]   load_data;
  logic                        load_ready;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);

endinterface

// File: rtl/scan_timer.sv
// Phase timer for the scan FSM: counts cycles spent in the current state.
// tc is high on the last cycle of the phase; clear restarts the count at zero.
module scan_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic [W-1:0] last,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = (cnt == last);

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller sharing one external two-digit decoder among N_DISP displays.
// New value sets are staged in a pending register and committed only at frame boundaries.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int N_DISP = 2,
  parameter int DWELL  = 4,
  parameter int BLANK  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  display_scan_ctrl_if.slave    load,
  output logic [DIGIT_W-1:0]    dec_number,
  input  logic [6:0]            dec_tens,
  input  logic [6:0]            dec_ones,
  output logic [6:0]            seg_out,
  output logic [2*N_DISP-1:0]   digit_en,
  output logic                  frame_start,
  output state_t                dbg_state
);

  localparam int SLOT_W = (N_DISP > 1) ? $clog2(N_DISP) : 1;
  localparam int TW     = 16;
  localparam int DE_W   = 2 * N_DISP;
  localparam int DW     = DIGIT_W * N_DISP;
  localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(N_DISP - 1);
  localparam logic [TW-1:0]     DWELL_LAST = TW'(DWELL - 1);
  localparam logic [TW-1:0]     BLANK_LAST = TW'(BLANK - 1);

  state_t              state;
  logic [SLOT_W-1:0]   slot;
  logic                en_q;
  logic [DIGIT_W-1:0]  active [N_DISP];
  logic [DW-1:0]       pending;
  logic                pend_flag;

  logic                run;
  logic                tc;
  logic                timer_clear;
  logic                boundary;
  logic                accept;
  logic [TW-1:0]       limit;
  logic [DE_W-1:0]     tens_mask;
  logic [DE_W-1:0]     ones_mask;

  // The first cycle after en rises is spent holding slot 0 BLANK_T, so a restarted
  // frame has the same shape as one reached by wrapping.
  always_comb begin
    run         = en & en_q;
    limit       = (state == ST_TENS || state == ST_ONES) ? DWELL_LAST : BLANK_LAST;
    timer_clear = ~run | tc;
    boundary    = run & tc & (state == ST_ONES) & (slot == LAST_SLOT);
    accept      = load.load_valid & ~pend_flag;
    tens_mask   = DE_W'(1) << {slot, 1'b1};
    ones_mask   = DE_W'(1) << {slot, 1'b0};
  end

  assign load.load_ready = ~pend_flag;
  assign dec_number      = active[slot];
  assign dbg_state       = state;

  scan_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (timer_clear),
    .last  (limit),
    .tc    (tc)
  );

  // en_q resets low so the first frame after reset is also marked by frame_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_BLANK_T;
      slot        <= '0;
      en_q        <= 1'b0;
      seg_out     <= SEG_OFF;
      digit_en    <= '0;
      frame_start <= 1'b0;
    end else begin
      en_q        <= en;
      frame_start <= (en & ~en_q) | boundary;

      if (!run) begin
        state <= ST_BLANK_T;
        slot  <= '0;
      end else if (tc) begin
        state <= next_state(state);
        if (state == ST_ONES) begin
          slot <= (slot == LAST_SLOT) ? '0 : slot + SLOT_W'(1);
        end
      end

      if (en && state == ST_TENS) begin
        seg_out  <= dec_tens;
        digit_en <= tens_mask;
      end else if (en && state == ST_ONES) begin
        seg_out  <= dec_ones;
        digit_en <= ones_mask;
      end else begin
        seg_out  <= SEG_OFF;
        digit_en <= '0;
      end
    end
  end

  // accept requires an empty pending slot and commit requires a full one, so they never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      pend_flag <= 1'b0;
      for (int i = 0; i < N_DISP; i++) begin
        active[i] <= '0;
      end
    end else if (accept) begin
      pending   <= load.load_data;
      pend_flag <= 1'b1;
    end else if (pend_flag && (boundary || !en)) begin
      for (int i = 0; i < N_DISP; i++) begin
        active[i] <= pending[DIGIT_W*i +: DIGIT_W];
      end
      pend_flag <= 1'b0;
    end
  end

endmodule
